// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and byte-lane helper for the scoreboarded register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int LANES_DEF = DATA_W_DEF / 8;
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending bits, issue handshake and registered pending count
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              rdy1,
  output logic              rdy2,
  output logic              iss_ready,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] pend, pend_next;
  logic set, inc, dec;
  assign rdy1 = ~pend[r1] | (regwrite & (wr == r1));
  assign rdy2 = ~pend[r2] | (regwrite & (wr == r2));
  assign iss_ready = ~res & (~pend[iss_rd] | (regwrite & (wr == iss_rd)));
  assign set = iss_valid & iss_ready & ~(ZERO_REG && iss_rd == '0);
  assign inc = set & ~pend[iss_rd];
  assign dec = regwrite & pend[wr] & ~(set & (iss_rd == wr));
  always_comb begin
    pend_next = pend;
    if (regwrite) pend_next[wr] = 1'b0;
    if (set) pend_next[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      pend <= '0;
      pend_cnt <= '0;
    end else begin
      pend <= pend_next;
      pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read one-write register file with byte enables, write bypass and scoreboard
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                res,
  input  logic [ADDR_W-1:0]   r1,
  input  logic [ADDR_W-1:0]   r2,
  output logic [DATA_W-1:0]   data1,
  output logic [DATA_W-1:0]   data2,
  output logic                rdy1,
  output logic                rdy2,
  input  logic                regwrite,
  input  logic [ADDR_W-1:0]   wr,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                iss_ready,
  output logic [ADDR_W:0]     pend_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB = lanes(DATA_W);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;
  logic byp;
  assign byp = ~res & regwrite & ~(ZERO_REG && wr == '0);
  always_comb begin
    merged = mem[wr];
    for (int i = 0; i < NB; i++) merged[8*i +: 8] = wbe[i] ? wd[8*i +: 8] : merged[8*i +: 8];
  end
  assign data1 = (ZERO_REG && r1 == '0) ? '0 : (byp && wr == r1) ? merged : mem[r1];
  assign data2 = (ZERO_REG && r2 == '0) ? '0 : (byp && wr == r2) ? merged : mem[r2];
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (byp) begin
      mem[wr] <= merged;
    end
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .res(res),
    .r1(r1),
    .r2(r2),
    .regwrite(regwrite),
    .wr(wr),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .rdy1(rdy1),
    .rdy2(rdy2),
    .iss_ready(iss_ready),
    .pend_cnt(pend_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized run against a register/pending-set reference model
module tb_regfile_sb;
  localparam int D = 32;
  logic clk = 1'b0;
  logic res, regwrite, iss_valid, rdy1, rdy2, iss_ready;
  logic [4:0] r1, r2, wr, iss_rd;
  logic [31:0] wd, data1, data2;
  logic [3:0] wbe;
  logic [5:0] pend_cnt;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk),
    .res(res),
    .r1(r1),
    .r2(r2),
    .data1(data1),
    .data2(data2),
    .rdy1(rdy1),
    .rdy2(rdy2),
    .regwrite(regwrite),
    .wr(wr),
    .wd(wd),
    .wbe(wbe),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .iss_ready(iss_ready),
    .pend_cnt(pend_cnt)
  );
  typedef struct {
    logic res, regwrite;
    logic [4:0] wr;
    logic [31:0] wd;
    logic [3:0] wbe;
    logic iss_valid;
    logic [4:0] iss_rd, r1, r2;
    logic [31:0] d1, d2;
    logic y1, y2, ir;
    logic [5:0] cnt;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] mreg [D];
  bit mpend [D];
  int n_cmp = 0, n_bad = 0;
  function automatic vec_t mk(input logic rs, input logic rw, input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic iv, input logic [4:0] ia, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2,
                              input logic y1, input logic y2, input logic ir, input logic [5:0] cnt);
    vec_t v;
    v.res = rs; v.regwrite = rw; v.wr = a; v.wd = d; v.wbe = be; v.iss_valid = iv; v.iss_rd = ia;
    v.r1 = a1; v.r2 = a2; v.d1 = e1; v.d2 = e2; v.y1 = y1; v.y2 = y2; v.ir = ir; v.cnt = cnt;
    return v;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (!res && regwrite && wr == a) return merge(mreg[a], wd, wbe);
    return mreg[a];
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input vec_t v, input int mode);
    logic m_ir;
    int m_cnt;
    @(negedge clk);
    res = v.res; regwrite = v.regwrite; wr = v.wr; wd = v.wd; wbe = v.wbe;
    iss_valid = v.iss_valid; iss_rd = v.iss_rd; r1 = v.r1; r2 = v.r2;
    #1;
    m_ir = !res && (!mpend[iss_rd] || (regwrite && wr == iss_rd));
    m_cnt = 0;
    for (int i = 0; i < D; i++) m_cnt += int'(mpend[i]);
    if (mode >= 1) begin
      check("model data1", data1, m_read(r1));
      check("model data2", data2, m_read(r2));
      check("model rdy1", rdy1, !mpend[r1] || (regwrite && wr == r1));
      check("model rdy2", rdy2, !mpend[r2] || (regwrite && wr == r2));
      check("model iss_ready", iss_ready, m_ir);
      check("model pend_cnt", pend_cnt, m_cnt);
    end
    if (mode == 2) begin
      check("tbl data1", data1, v.d1);
      check("tbl data2", data2, v.d2);
      check("tbl rdy1", rdy1, v.y1);
      check("tbl rdy2", rdy2, v.y2);
      check("tbl iss_ready", iss_ready, v.ir);
      check("tbl pend_cnt", pend_cnt, v.cnt);
    end
    @(posedge clk);
    if (v.res) begin
      for (int i = 0; i < D; i++) begin
        mreg[i] = 0;
        mpend[i] = 0;
      end
    end else begin
      if (v.regwrite && v.wr != 0) mreg[v.wr] = merge(mreg[v.wr], v.wd, v.wbe);
      if (v.regwrite) mpend[v.wr] = 0;
      if (v.iss_valid && m_ir && v.iss_rd != 0) mpend[v.iss_rd] = 1;
    end
  endtask
  function automatic logic [4:0] ra();
    return ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'($urandom % 8);
  endfunction
  initial begin
    vec_t v;
    for (int i = 0; i < D; i++) begin
      mreg[i] = 0;
      mpend[i] = 0;
    end
    tbl.push_back(mk(0, 1, 14, 21, 4'hF, 0, 0, 14, 15, 21, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 15, 12, 4'hF, 0, 0, 14, 15, 21, 12, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 14, 15, 21, 12, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5, 32'h11223344, 4'hF, 0, 0, 5, 14, 32'h11223344, 21, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 5, 15, 32'h11BB33DD, 12, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 5, 0, 32'h11BB33DD, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 7, 7, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 7, 7, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 7, 32'h55, 4'hF, 0, 7, 7, 0, 32'h55, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 7, 0, 32'h55, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 9, 9, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 9, 3, 4'hF, 1, 9, 9, 0, 3, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 9, 9, 0, 3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 9, 3, 4'hF, 0, 9, 9, 0, 3, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 1, 1, 2, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 2, 1, 2, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 3, 1, 2, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4, 1, 2, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(1, 1, 1, 32'hDEAD, 4'hF, 1, 5, 1, 14, 0, 21, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 14, 5, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 4, 0, 0, 1, 1, 1, 0));
    v = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(v, 0);
    step(v, 0);
    foreach (tbl[k]) step(tbl[k], 2);
    for (int n = 0; n < 3000; n++) begin
      v = mk($urandom % 64 == 0, $urandom % 3 != 0, ra(), $urandom, 4'($urandom), $urandom % 2 == 0,
             ra(), ra(), ra(), 0, 0, 0, 0, 0, 0);
      step(v, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
